// File: rtl/add16_arb_pkg.sv
// Shared types and constants for the add16 round-robin arbiter.
package add16_arb_pkg;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef logic [15:0] word_t;

  localparam int unsigned DEFAULT_MAXBURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_gnt_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr_i) + i) % NREQ);
      if (!any_gnt_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        any_gnt_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add16_rr_arbiter.sv
// Round-robin arbiter sharing one external 16-bit adder between NREQ requesters.
// Define ADD16_ARB_LOCK_EN to add req_lock burst locking (up to MAXBURST grants).
module add16_rr_arbiter
  import add16_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
`ifdef ADD16_ARB_LOCK_EN
  ,
  parameter int unsigned MAXBURST = DEFAULT_MAXBURST
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ-1:0]    req_cin,
`ifdef ADD16_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [15:0]        add_a,
  output logic [15:0]        add_b,
  output logic               add_cin,
  input  logic [15:0]        add_r,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [15:0]        res_r,
  input  logic               res_ready
);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, ptr_next;
  logic [IDW-1:0] res_id_q;
  word_t          res_r_q;

  logic [NREQ-1:0] pick_req, gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any_gnt, can_issue;

`ifdef ADD16_ARB_LOCK_EN
  localparam int unsigned BW = $clog2(MAXBURST) + 1;
  localparam logic [BW-1:0] BurstLast = BW'(MAXBURST - 1);
  logic [BW-1:0] burst_q, burst_d, burst_base;
`endif

  assign res_valid = (state_q == FULL);
  assign res_id    = res_id_q;
  assign res_r     = res_r_q;

  assign can_issue = (state_q == EMPTY) || (res_valid && res_ready);
  // Gating with reset keeps req_ready and the adder operands at 0 while in reset.
  assign pick_req  = req_valid & {NREQ{can_issue && !reset}};

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i     (pick_req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        add_a   = req_a[i*16 +: 16];
        add_b   = req_b[i*16 +: 16];
        add_cin = req_cin[i];
      end
    end
  end

  assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
`ifdef ADD16_ARB_LOCK_EN
    burst_d    = burst_q;
    // A locked owner keeps ptr pointing at itself, so a grant elsewhere restarts the count.
    burst_base = (gnt_idx == ptr_q) ? burst_q : '0;
`endif

    case (state_q)
      EMPTY:   if (any_gnt) state_d = FULL;
      FULL:    if (res_ready && !any_gnt) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (any_gnt) begin
`ifdef ADD16_ARB_LOCK_EN
      if (req_lock[gnt_idx] && (burst_base < BurstLast)) begin
        ptr_d   = gnt_idx;
        burst_d = burst_base + BW'(1);
      end else begin
        ptr_d   = ptr_next;
        burst_d = '0;
      end
`else
      ptr_d = ptr_next;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      res_id_q <= '0;
      res_r_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (any_gnt) begin
        res_r_q  <= add_r;
        res_id_q <= gnt_idx;
      end
    end
  end

`ifdef ADD16_ARB_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`endif

endmodule

// File: tb/tb_add16_rr_arbiter.sv
// Scoreboard bench for add16_rr_arbiter; define ADD16_ARB_LOCK_EN to also exercise locking.
module tb_add16_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef ADD16_ARB_LOCK_EN
  localparam int MAXB = 4;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    r;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_a, req_b;
  logic [NREQ-1:0]    req_cin;
`ifdef ADD16_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;
`endif
  logic [15:0]        add_a, add_b, add_r;
  logic               add_cin;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [15:0]        res_r;
  logic               res_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ptr_m   = 0;
  int   cnt_m   = 0;
  bit   full_m  = 1'b0;
  int   model_g = -1;
  int   last_gnt = -1;
  int   gcnt [NREQ];
  exp_t q [$];

  always #5 clk = ~clk;

  // Stand-in for the external shared adder.
  assign add_r = add_a + add_b + {15'b0, add_cin};

  add16_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADD16_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_r     (add_r),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_r     (res_r),
    .res_ready (res_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
    req_a[k*16 +: 16] = a;
    req_b[k*16 +: 16] = b;
    req_cin[k]        = c;
  endtask

  function automatic int model_pick();
    if (full_m && !res_ready) return -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (ptr_m + i) % NREQ;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    full_m = 1'b0;
    ptr_m  = 0;
    cnt_m  = 0;
    q.delete();
  endtask

  // One clock: check at the negedge, advance the model, return at posedge + 1.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [15:0] s;
    exp_t e;
    @(negedge clk);
    g = model_pick();
    model_g = g;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("res_valid", 32'(res_valid), 32'(full_m));
    last_gnt = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        last_gnt = i;
        gcnt[i]++;
      end
    end
    if (g >= 0) begin
      s = req_a[g*16 +: 16] + req_b[g*16 +: 16] + {15'b0, req_cin[g]};
      check_eq("add_a", 32'(add_a), 32'(req_a[g*16 +: 16]));
      check_eq("add_b", 32'(add_b), 32'(req_b[g*16 +: 16]));
    end else begin
      s = '0;
      check_eq("add_a_idle", 32'(add_a), 32'd0);
    end
    if (full_m) begin
      check_eq("sb_size", 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
        check_eq("res_r", 32'(res_r), 32'(q[0].r));
        check_eq("res_id", 32'(res_id), 32'(q[0].id));
        if (res_ready) q.delete(0);
      end
    end
    if (g >= 0) begin
      e.id = IDW'(g);
      e.r  = s;
      q.push_back(e);
      full_m = 1'b1;
`ifdef ADD16_ARB_LOCK_EN
      begin
        int base;
        base = (g == ptr_m) ? cnt_m : 0;
        if (req_lock[g] && base < MAXB - 1) begin
          ptr_m = g;
          cnt_m = base + 1;
        end else begin
          ptr_m = (g + 1) % NREQ;
          cnt_m = 0;
        end
      end
`else
      ptr_m = (g + 1) % NREQ;
`endif
    end else if (res_ready) begin
      full_m = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    req_a     = '1;
    req_b     = '1;
    req_cin   = '1;
    res_ready = 1'b0;
`ifdef ADD16_ARB_LOCK_EN
    req_lock  = '0;
`endif
    foreach (gcnt[i]) gcnt[i] = 0;

    // Reset values, with requests pending so the reset gating is visible.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_id", 32'(res_id), 32'd0);
    check_eq("rst_res_r", 32'(res_r), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_add", {15'b0, add_cin, add_a}, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = '0;
    model_reset();

    // Single request.
    set_op(0, 16'h1234, 16'h0F0F, 1'b1);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    step();
    check_eq("single_gnt", 32'(last_gnt), 32'd0);
    req_valid = '0;
    check_eq("single_r", 32'(res_r), 32'h2144);
    check_eq("single_valid", 32'(res_valid), 32'd1);
    step();

    // Fairness: all valid for 8 cycles.
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
      gcnt[i] = 0;
    end
    req_valid = '1;
    repeat (8) step();
    for (int i = 0; i < NREQ; i++) check_eq($sformatf("fair_cnt%0d", i), 32'(gcnt[i]), 32'd2);
    req_valid = '0;
    step();

    // Back-pressure with 0xFFFF held.
    set_op(3, 16'hFFFE, 16'h0000, 1'b1);
    req_valid = 4'b1000;
    res_ready = 1'b0;
    step();
    set_op(1, 16'h0100, 16'h0011, 1'b0);
    req_valid = 4'b0010;
    repeat (3) step();
    check_eq("bp_held", 32'(res_r), 32'hFFFF);
    res_ready = 1'b1;
    step();
    check_eq("bp_gnt", 32'(last_gnt), 32'd1);
    req_valid = '0;
    check_eq("bp_new_r", 32'(res_r), 32'h0111);
    step();

    // Wrap-around.
    set_op(0, 16'hFFFF, 16'h0001, 1'b0);
    req_valid = 4'b0001;
    step();
    check_eq("wrap0", 32'(res_r), 32'h0000);
    set_op(0, 16'h8000, 16'h8000, 1'b1);
    step();
    check_eq("wrap1", 32'(res_r), 32'h0001);
    req_valid = '0;
    step();

    // Random traffic.
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || model_g == i) begin
          set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
          req_valid[i] = 1'($urandom);
        end
      end
      res_ready = ($urandom_range(3) != 0);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    step();

    // Reset with a result pending.
    set_op(2, 16'h0042, 16'h0001, 1'b0);
    req_valid = 4'b0100;
    res_ready = 1'b0;
    step();
    set_op(0, 16'h0003, 16'h0004, 1'b0);
    req_valid = 4'b0101;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(res_valid), 32'd0);
    check_eq("mid_rst_r", 32'(res_r), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    res_ready = 1'b1;
    step();
    check_eq("post_rst_gnt", 32'(last_gnt), 32'd0);
    req_valid = '0;
    step();

`ifdef ADD16_ARB_LOCK_EN
    begin
      int exp_seq [7];
      exp_seq = '{0, 2, 2, 2, 2, 0, 2};
      reset = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      reset    = 1'b0;
      req_lock = 4'b0100;
      set_op(0, 16'h0010, 16'h0020, 1'b0);
      set_op(2, 16'h0300, 16'h0400, 1'b1);
      req_valid = 4'b0101;
      for (int i = 0; i < 7; i++) begin
        step();
        check_eq($sformatf("lock_seq%0d", i), 32'(last_gnt), 32'(exp_seq[i]));
      end
      req_valid = '0;
      req_lock  = '0;
      step();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
